// File: rtl/delay_line_ctrl.sv
`default_nettype none
// ============================================================================
//  delay_line_ctrl
//  Circular-buffer write/read controller for a dual-port sample RAM. Every
//  accepted sample also reads back the sample `offset` positions earlier.
//  Revision: 1.0  initial release
// ============================================================================
module delay_line_ctrl #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               sample_valid,
    input  logic [D_WIDTH-1:0] sample_in,
    input  logic [A_WIDTH-1:0] offset,
    output logic               wr_en,
    output logic [A_WIDTH-1:0] wr_addr,
    output logic [D_WIDTH-1:0] din,
    output logic               rd_en,
    output logic [A_WIDTH-1:0] rd_addr,
    input  logic [D_WIDTH-1:0] ram_dout,
    output logic [D_WIDTH-1:0] delayed_out,
    output logic               delayed_valid,
    output logic               primed
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t             r_state;
    logic [A_WIDTH-1:0] r_wr_ptr;
    logic [A_WIDTH-1:0] r_fill_cnt;
    logic               r_rd_pend;

    logic [A_WIDTH-1:0] w_off_eff;
    logic               w_hist_ok;
    logic               w_fill_sat;

    // Zero delay would read and write one address on the same edge, which
    // returns the stale word, so it is treated as a delay of one.
    assign w_off_eff  = (offset == '0) ? A_WIDTH'(1) : offset;
    assign w_hist_ok  = (r_fill_cnt >= w_off_eff);
    assign w_fill_sat = &r_fill_cnt;
    assign primed     = (r_state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= EMPTY;
            r_wr_ptr      <= '0;
            r_fill_cnt    <= '0;
            r_rd_pend     <= 1'b0;
            wr_en         <= 1'b0;
            wr_addr       <= '0;
            din           <= '0;
            rd_en         <= 1'b0;
            rd_addr       <= '0;
            delayed_out   <= '0;
            delayed_valid <= 1'b0;
        end else begin
            // The read return path keeps running through a flush.
            r_rd_pend     <= rd_en;
            delayed_out   <= ram_dout;
            delayed_valid <= r_rd_pend;

            if (flush) begin
                r_state    <= EMPTY;
                r_wr_ptr   <= '0;
                r_fill_cnt <= '0;
                wr_en      <= 1'b0;
                rd_en      <= 1'b0;
            end else if (sample_valid) begin
                wr_en    <= 1'b1;
                wr_addr  <= r_wr_ptr;
                din      <= sample_in;
                r_wr_ptr <= r_wr_ptr + 1'b1;
                rd_en    <= w_hist_ok;
                if (w_hist_ok) begin
                    rd_addr <= r_wr_ptr - w_off_eff;
                end
                if (!w_fill_sat) begin
                    r_fill_cnt <= r_fill_cnt + 1'b1;
                end
                r_state <= w_hist_ok ? RUN : FILL;
            end else begin
                wr_en <= 1'b0;
                rd_en <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_delay_line_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_delay_line_ctrl
//  Directed bench for delay_line_ctrl with a behavioural synchronous RAM.
//  Revision: 1.0  initial release
// ============================================================================
module tb_delay_line_ctrl;

    localparam int C_AW = 9;
    localparam int C_DW = 8;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic            sample_valid;
    logic [C_DW-1:0] sample_in;
    logic [C_AW-1:0] offset;
    logic            wr_en;
    logic [C_AW-1:0] wr_addr;
    logic [C_DW-1:0] din;
    logic            rd_en;
    logic [C_AW-1:0] rd_addr;
    logic [C_DW-1:0] ram_dout;
    logic [C_DW-1:0] delayed_out;
    logic            delayed_valid;
    logic            primed;

    logic [C_DW-1:0] r_mem [0:(1<<C_AW)-1];

    int n_cmp = 0;
    int n_err = 0;

    // expected delayed result for the samples one, two and three steps back
    logic            q1v, q2v, q3v;
    logic [C_DW-1:0] q1d, q2d, q3d;
    logic [C_AW-1:0] exp_wa;

    delay_line_ctrl #(.A_WIDTH(C_AW), .D_WIDTH(C_DW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .offset       (offset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .din          (din),
        .rd_en        (rd_en),
        .rd_addr      (rd_addr),
        .ram_dout     (ram_dout),
        .delayed_out  (delayed_out),
        .delayed_valid(delayed_valid),
        .primed       (primed)
    );

    always #5 clk = ~clk;

    // Read-before-write dual-port RAM
    always @(posedge clk) begin
        if (wr_en) r_mem[wr_addr] <= din;
        if (rd_en) ram_dout <= r_mem[rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clr_pipe();
        q1v = 1'b0; q2v = 1'b0; q3v = 1'b0;
        q1d = '0;   q2d = '0;   q3d = '0;
        exp_wa = '0;
    endtask

    // One clock of stimulus; erd/ev are the hand-derived read decision and
    // delayed value for this sample, checked as they emerge two edges later.
    task automatic step(input logic v, input logic [C_DW-1:0] d, input logic [C_AW-1:0] off,
                        input logic f, input logic erd, input logic [C_DW-1:0] ev);
        sample_valid = v;
        sample_in    = d;
        offset       = off;
        flush        = f;
        @(posedge clk);
        #1;
        q3v = q2v; q3d = q2d;
        q2v = q1v; q2d = q1d;
        q1v = erd && v && !f; q1d = ev;
        chk("wr_en", wr_en, v && !f);
        chk("rd_en", rd_en, erd && v && !f);
        if (f) begin
            exp_wa = '0;
        end else if (v) begin
            chk("wr_addr", wr_addr, exp_wa);
            chk("din", din, d);
            exp_wa = exp_wa + 1'b1;
        end
        chk("dly_valid", delayed_valid, q3v);
        if (q3v) chk("dly_out", delayed_out, q3d);
    endtask

    task automatic idle();
        step(1'b0, '0, offset, 1'b0, 1'b0, '0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; sample_valid = 1'b1; sample_in = 8'h55; offset = 9'd2;
        clr_pipe();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_din", din, 0);
        chk("rst_rd_en", rd_en, 0);
        chk("rst_rd_addr", rd_addr, 0);
        chk("rst_dly_out", delayed_out, 0);
        chk("rst_dly_valid", delayed_valid, 0);
        chk("rst_primed", primed, 0);
        sample_valid = 1'b0;
        rst_n = 1'b1;

        // samples 1,2,3 at offset 2: only the third reads, from address 0
        step(1'b1, 8'd1, 9'd2, 1'b0, 1'b0, 8'd0);
        chk("t1_primed0", primed, 0);
        step(1'b1, 8'd2, 9'd2, 1'b0, 1'b0, 8'd0);
        step(1'b1, 8'd3, 9'd2, 1'b0, 1'b1, 8'd1);
        chk("t1_rd_addr", rd_addr, 0);
        chk("t1_primed1", primed, 1);
        idle(); idle(); idle();

        // continuous stream with pointer wrap
        step(1'b0, '0, 9'd5, 1'b1, 1'b0, '0);
        for (int n = 0; n < 600; n++) begin
            step(1'b1, C_DW'(n), 9'd5, 1'b0, n >= 5, C_DW'(n - 5));
            chk("t2_primed", primed, n >= 5);
        end
        idle(); idle();

        // zero offset behaves as one
        step(1'b0, '0, 9'd0, 1'b1, 1'b0, '0);
        for (int i = 0; i < 6; i++)
            step(1'b1, C_DW'(10 * (i + 1)), 9'd0, 1'b0, i >= 1, C_DW'(10 * i));
        idle(); idle();

        // offset raised 3 -> 10 while running
        step(1'b0, '0, 9'd3, 1'b1, 1'b0, '0);
        for (int n = 0; n < 6; n++)
            step(1'b1, C_DW'(n + 100), 9'd3, 1'b0, n >= 3, C_DW'(n + 97));
        chk("t4_primed_run", primed, 1);
        for (int n = 6; n < 16; n++) begin
            step(1'b1, C_DW'(n + 100), 9'd10, 1'b0, n >= 10, C_DW'(n + 90));
            if (n == 6)  chk("t4_primed_drop", primed, 0);
            if (n == 10) chk("t4_primed_back", primed, 1);
        end
        idle(); idle();

        // flush together with a sample after 20 samples
        step(1'b0, '0, 9'd4, 1'b1, 1'b0, '0);
        for (int n = 0; n < 20; n++)
            step(1'b1, C_DW'(n + 1), 9'd4, 1'b0, n >= 4, C_DW'(n - 3));
        step(1'b1, 8'hEE, 9'd4, 1'b1, 1'b0, '0);
        chk("t5_primed", primed, 0);
        for (int k = 0; k < 6; k++)
            step(1'b1, C_DW'(8'h70 + k), 9'd4, 1'b0, k >= 4, C_DW'(8'h70 + k - 4));
        idle(); idle();

        // gapped input, every third cycle
        step(1'b0, '0, 9'd4, 1'b1, 1'b0, '0);
        for (int n = 0; n < 9; n++) begin
            step(1'b1, C_DW'(200 + n), 9'd4, 1'b0, n >= 4, C_DW'(196 + n));
            idle(); idle();
        end
        step(1'b1, 8'd209, 9'd4, 1'b0, 1'b1, 8'd205);

        // asynchronous reset mid-stream clears outputs and drops in-flight read
        #2 rst_n = 1'b0;
        #1;
        chk("ar_wr_en", wr_en, 0);
        chk("ar_rd_en", rd_en, 0);
        chk("ar_wr_addr", wr_addr, 0);
        chk("ar_primed", primed, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        clr_pipe();
        idle(); idle(); idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
